// File: rtl/restador_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package restador_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int RESTADOR_WIDTH = 8;

endpackage

// File: rtl/restador1.sv
// Combinational 1-bit full subtractor: d = a ^ b ^ bw, borrow = (~a & b) | (~(a ^ b) & bw).
module restador1 (
  input  logic a_i,
  input  logic b_i,
  input  logic bw_i,
  output logic d_o,
  output logic bw_o
);

  wire ab_x;
  wire ab_xn;
  wire a_n;
  wire bw_gen;
  wire bw_prop;
  wire d_w;
  wire bw_w;

  xor g_x0 (ab_x, a_i, b_i);
  xor g_x1 (d_w, ab_x, bw_i);
  not g_n0 (a_n, a_i);
  not g_n1 (ab_xn, ab_x);
  and g_a0 (bw_gen, a_n, b_i);
  and g_a1 (bw_prop, ab_xn, bw_i);
  or  g_o0 (bw_w, bw_gen, bw_prop);

  assign d_o  = d_w;
  assign bw_o = bw_w;

endmodule

// File: rtl/restador_serial.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor step per clock,
// with start/ready operand handshake and valid/ack result handshake.
module restador_serial
  import restador_pkg::*;
#(
  parameter int WIDTH = RESTADOR_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ack_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] d_o,
  output logic             bw_o,
  output logic             z_o,
  output logic             ov_o
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] d_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             bw_reg;
  logic             bw_msb_reg;
  logic             cell_d;
  logic             cell_bw;
  logic             last_step;

  restador1 u_cell (
    .a_i  (a_reg[0]),
    .b_i  (b_reg[0]),
    .bw_i (bw_reg),
    .d_o  (cell_d),
    .bw_o (cell_bw)
  );

  assign last_step = (cnt_reg == CNT_LAST);

  // New difference bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_dshift
      assign d_next[gi] = d_reg[gi+1];
    end
  endgenerate
  assign d_next[WIDTH-1] = cell_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_i) state_next = ST_SHIFT;
      ST_SHIFT: if (last_step) state_next = ST_DONE;
      ST_DONE:  if (ack_i) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_reg == ST_IDLE);
    valid_o = (state_reg == ST_DONE);
    z_o     = valid_o & ~|d_reg;
    ov_o    = valid_o & (bw_msb_reg ^ bw_reg);
  end

  assign d_o  = d_reg;
  assign bw_o = bw_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_reg      <= '0;
      b_reg      <= '0;
      d_reg      <= '0;
      cnt_reg    <= '0;
      bw_reg     <= 1'b0;
      bw_msb_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            a_reg      <= a_i;
            b_reg      <= b_i;
            cnt_reg    <= '0;
            bw_reg     <= 1'b0;
            bw_msb_reg <= 1'b0;
          end
        end
        ST_SHIFT: begin
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          d_reg  <= d_next;
          bw_reg <= cell_bw;
          // Borrow into the MSB, needed for signed overflow; counter returns to 0 with the state change.
          if (last_step) begin
            bw_msb_reg <= bw_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restador_serial.sv
// Self-checking bench for restador_serial (WIDTH=8): directed cases plus a random sweep
// compared against an arithmetic reference model.
module tb_restador_serial;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         ack_i;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] d_o;
  logic         bw_o;
  logic         z_o;
  logic         ov_o;

  int n_checks = 0;
  int n_fail   = 0;

  restador_serial #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .ack_i   (ack_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .d_o     (d_o),
    .bw_o    (bw_o),
    .z_o     (z_o),
    .ov_o    (ov_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction: start, wait for valid, check result, hold ack low for ack_dly cycles, release.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int ack_dly,
                        input bit pulse_mid, input bit verbose);
    logic [8:0] diff;
    logic [7:0] ed;
    logic       ebw;
    logic       eov;
    int         lat;
    diff = {1'b0, a} - {1'b0, b};
    ed   = diff[7:0];
    ebw  = diff[8];
    eov  = (a[7] ^ b[7]) & (a[7] ^ ed[7]);

    lat = 0;
    while (!ready_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    check_eq("ready_pre", ready_o, 1);
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    ack_i   = (ack_dly == 0);
    @(negedge clk_i);
    start_i = 1'b0;
    a_i     = W'($urandom);
    b_i     = W'($urandom);
    check_eq("ready_busy", ready_o, 0);

    lat = 0;
    while (!valid_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
      if (pulse_mid && lat == 3) begin
        start_i = 1'b1;
        a_i     = 8'h11;
        b_i     = 8'hEE;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    check_eq("latency", lat, 8);
    check_eq("valid", valid_o, 1);
    check_eq("d", d_o, ed);
    check_eq("bw", bw_o, ebw);
    check_eq("z", z_o, (ed == 8'h00));
    check_eq("ov", ov_o, eov);

    for (int i = 0; i < ack_dly; i++) begin
      start_i = (i == 0);
      a_i     = 8'h77;
      b_i     = 8'h99;
      @(negedge clk_i);
      start_i = 1'b0;
      check_eq("hold_valid", valid_o, 1);
      check_eq("hold_d", d_o, ed);
      check_eq("hold_bw", bw_o, ebw);
    end
    ack_i = 1'b1;
    @(negedge clk_i);
    check_eq("valid_drop", valid_o, 0);
    check_eq("ready_back", ready_o, 1);
    check_eq("z_idle", z_o, 0);
    check_eq("ov_idle", ov_o, 0);
    ack_i = 1'b0;
    if (verbose)
      $display("op a=%02h b=%02h -> d=%02h bw=%0b ov=%0b lat=%0d", a, b, ed, ebw, eov, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_valid;
    rst_i   = 1'b1;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    ack_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_ready", ready_o, 1);
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_d", d_o, 0);
    check_eq("rst_bw", bw_o, 0);
    check_eq("rst_z", z_o, 0);
    check_eq("rst_ov", ov_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_op(8'h05, 8'h03, 0, 1'b0, 1'b1);
    run_op(8'h03, 8'h05, 0, 1'b0, 1'b1);
    run_op(8'h80, 8'h01, 0, 1'b0, 1'b1);
    run_op(8'h2A, 8'h2A, 5, 1'b1, 1'b1);

    // Reset in the middle of an operation.
    a_i     = 8'hFF;
    b_i     = 8'h01;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_eq("midrst_ready", ready_o, 1);
    check_eq("midrst_valid", valid_o, 0);
    check_eq("midrst_d", d_o, 0);
    check_eq("midrst_bw", bw_o, 0);
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk_i);
      if (valid_o) saw_valid = 1'b1;
    end
    check_eq("midrst_no_valid", saw_valid, 0);
    $display("op mid-operation reset: ready=%0b valid=%0b d=%02h", ready_o, valid_o, d_o);

    // Reset and start in the same cycle: start is dropped.
    rst_i   = 1'b1;
    start_i = 1'b1;
    a_i     = 8'h10;
    b_i     = 8'h01;
    @(negedge clk_i);
    rst_i   = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_start_ready", ready_o, 1);
    check_eq("rst_start_valid", valid_o, 0);
    $display("op reset+start same cycle: ready=%0b", ready_o);

    for (int n = 0; n < 1000; n++) begin
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end
    $display("random sweep: 1000 operations");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
